// File: rtl/cpu_defs.sv
// Shared pipeline definitions: inter-stage bus structs, load-op encoding,
// CP0/TLB op enums and the flush request bundle.
package cpu_defs;

  // One-hot load_op bit positions
  localparam int LOAD_OP_W = 7;
  localparam int LD_LW     = 0;
  localparam int LD_LB     = 1;
  localparam int LD_LBU    = 2;
  localparam int LD_LH     = 3;
  localparam int LD_LHU    = 4;
  localparam int LD_LWL    = 5;
  localparam int LD_LWR    = 6;

  typedef enum logic [1:0] {
    C0_NONE = 2'd0,
    C0_MFC0 = 2'd1,
    C0_MTC0 = 2'd2,
    C0_ERET = 2'd3
  } c0_op_e;

  typedef enum logic [1:0] {
    TLB_NONE  = 2'd0,
    TLB_TLBP  = 2'd1,
    TLB_TLBR  = 2'd2,
    TLB_TLBWI = 2'd3
  } tlb_op_e;

  typedef struct packed {
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
  } exception_t;

  typedef struct packed {
    logic eret;
    logic ex;
  } pipeline_flush_t;

  typedef struct packed {
    logic                 valid;
    logic [LOAD_OP_W-1:0] load_op;
    c0_op_e               c0_op;
    logic [7:0]           c0_addr;
    logic                 req_ok;
    logic                 res_from_mem;
    logic                 res_to_mem;
    logic                 rf_we;
    logic [4:0]           dest;
    logic [31:0]          result;   // vaddr for loads/stores
    logic [31:0]          rt_data;  // old rt value, merged by lwl/lwr
    logic [31:0]          pc;
    exception_t           exception;
    tlb_op_e              tlb_op;
  } pms_to_ms_bus_t;

  typedef struct packed {
    logic        valid;
    c0_op_e      c0_op;
    logic [7:0]  c0_addr;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
    exception_t  exception;
    tlb_op_e     tlb_op;
  } ms_to_ws_bus_t;

  typedef struct packed {
    logic        op_mfc0;
    logic        data_pending;
    logic        op_tlb;
    logic [4:0]  dest;
    logic [31:0] final_result;
  } ms_forward_bus_t;

  // Extend a byte or halfword to 32 bits, signed or unsigned
  function automatic logic [31:0] ext8(input logic [7:0] v, input logic sign);
    return {{24{sign & v[7]}}, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sign);
    return {{16{sign & v[15]}}, v};
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks and extends the addressed byte/halfword, or
// merges partial words for lwl/lwr, from a little-endian 32-bit read word.
module load_align
  import cpu_defs::*;
(
  input  logic [LOAD_OP_W-1:0] load_op,
  input  logic [1:0]           addr,
  input  logic [31:0]          rdata,
  input  logic [31:0]          rt_data,
  output logic [31:0]          aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lwl_val;
  logic [31:0] lwr_val;

  // Select candidate values for every load flavour from the byte offset
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    byte_sel = rdata[7:0];
    lwl_val  = rdata;
    lwr_val  = rdata;
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (addr)
      2'd0: begin
        byte_sel = rdata[7:0];
        lwl_val  = {rdata[7:0], rt_data[23:0]};
        lwr_val  = rdata;
      end
      2'd1: begin
        byte_sel = rdata[15:8];
        lwl_val  = {rdata[15:0], rt_data[15:0]};
        lwr_val  = {rt_data[31:24], rdata[31:8]};
      end
      2'd2: begin
        byte_sel = rdata[23:16];
        lwl_val  = {rdata[23:0], rt_data[7:0]};
        lwr_val  = {rt_data[31:16], rdata[31:16]};
      end
      default: begin
        byte_sel = rdata[31:24];
        lwl_val  = rdata;
        lwr_val  = {rt_data[31:8], rdata[31:24]};
      end
    endcase
  end

  // One-hot AND-OR mux across load flavours; no load selected yields zero
  always_comb begin
    aligned = ({32{load_op[LD_LW]}}  & rdata)
            | ({32{load_op[LD_LB]}}  & ext8(byte_sel, 1'b1))
            | ({32{load_op[LD_LBU]}} & ext8(byte_sel, 1'b0))
            | ({32{load_op[LD_LH]}}  & ext16(half_sel, 1'b1))
            | ({32{load_op[LD_LHU]}} & ext16(half_sel, 1'b0))
            | ({32{load_op[LD_LWL]}} & lwl_val)
            | ({32{load_op[LD_LWR]}} & lwr_val);
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-response stage: holds one instruction from pre-MEM, waits for its
// in-order data-SRAM response, aligns load data and hands the result to WB
// and the ID bypass network. Responses of flushed requests are discarded.
module mem_stage
  import cpu_defs::*;
#(
  parameter int CANCEL_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ws_allowin,
  output logic            ms_allowin,
  input  pms_to_ms_bus_t  pms_to_ms_bus,
  output ms_to_ws_bus_t   ms_to_ws_bus,
  output ms_forward_bus_t ms_forward_bus,
  output logic            ms_wr_disable,
  input  pipeline_flush_t pipeline_flush,
  input  logic [31:0]     data_rdata,
  input  logic            data_data_ok
);

  // At most the waiting instruction plus the one issued upstream can be cut off
  localparam logic [CANCEL_W:0] CANCEL_MAX = (CANCEL_W+1)'(2);

  logic                ms_valid;
  logic                waiting;
  logic                buf_valid;
  logic [CANCEL_W-1:0] cancel_cnt;
  logic [31:0]         data_buf;
  pms_to_ms_bus_t      ms_bus;

  logic                flush;
  logic                own_data_ok;
  logic                drop_data_ok;
  logic                ms_ready_go;
  logic [1:0]          cancel_inc;
  logic [CANCEL_W:0]   cancel_next;
  logic [31:0]         rdata_sel;
  logic [31:0]         aligned;
  logic [31:0]         final_result;

  assign flush = pipeline_flush.eret | pipeline_flush.ex;

  // Steer a response: stale ones go to the discard counter first
  always_comb begin
    drop_data_ok = data_data_ok & (cancel_cnt != '0);
    own_data_ok  = data_data_ok & (cancel_cnt == '0) & waiting;
    ms_ready_go  = !waiting | own_data_ok | buf_valid | ms_bus.exception.ex;
    ms_allowin   = !ms_valid | (ms_ready_go & ws_allowin);
  end

  // Requests left without an owner on a flush: this stage's pending one plus
  // any request pre-MEM issues in the very same cycle
  always_comb begin
    cancel_inc = 2'd0;
    if (flush) begin
      cancel_inc = 2'(ms_valid & waiting & ~own_data_ok) + 2'(pms_to_ms_bus.req_ok);
    end
    cancel_next = {1'b0, cancel_cnt} + (CANCEL_W+1)'(cancel_inc)
                - (CANCEL_W+1)'(drop_data_ok);
  end

  // Control state: valid, wait, stall buffer and discard counter
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset) begin
      ms_valid   <= 1'b0;
      waiting    <= 1'b0;
      buf_valid  <= 1'b0;
      cancel_cnt <= '0;
    end else begin
      cancel_cnt <= cancel_next[CANCEL_W-1:0];
      if (flush) begin
        ms_valid  <= 1'b0;
        waiting   <= 1'b0;
        buf_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid  <= pms_to_ms_bus.valid;
        waiting   <= pms_to_ms_bus.req_ok;
        buf_valid <= 1'b0;
      end else if (own_data_ok) begin
        // Response arrived while WB is stalled: park it until the instruction leaves
        buf_valid <= 1'b1;
        waiting   <= 1'b0;
      end
    end
  end

  // Datapath registers: instruction bus and parked response word
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are not reset; they are only observed while the valid/buffer flags qualify them.
    if (pms_to_ms_bus.valid && ms_allowin) begin
      ms_bus <= pms_to_ms_bus;
    end
    if (own_data_ok && !ms_allowin && !flush) begin
      data_buf <= data_rdata;
    end
  end

  assign rdata_sel = buf_valid ? data_buf : data_rdata;

  load_align u_load_align (
    .load_op (ms_bus.load_op),
    .addr    (ms_bus.result[1:0]),
    .rdata   (rdata_sel),
    .rt_data (ms_bus.rt_data),
    .aligned (aligned)
  );

  assign final_result = ms_bus.res_from_mem ? aligned : ms_bus.result;

  // WB bus: valid follows the response combinationally
  always_comb begin
    ms_to_ws_bus              = '0;
    ms_to_ws_bus.valid        = ms_valid & ms_ready_go;
    ms_to_ws_bus.c0_op        = ms_bus.c0_op;
    ms_to_ws_bus.c0_addr      = ms_bus.c0_addr;
    ms_to_ws_bus.rf_we        = ms_bus.rf_we;
    ms_to_ws_bus.dest         = ms_bus.dest;
    ms_to_ws_bus.final_result = final_result;
    ms_to_ws_bus.pc           = ms_bus.pc;
    ms_to_ws_bus.exception    = ms_bus.exception;
    ms_to_ws_bus.tlb_op       = ms_bus.tlb_op;
  end

  // Bypass bus to ID: everything qualified by ms_valid; loads still waiting
  // raise data_pending so ID stalls instead of taking a stale value
  always_comb begin
    ms_forward_bus              = '0;
    ms_forward_bus.op_mfc0      = ms_valid & (ms_bus.c0_op == C0_MFC0);
    ms_forward_bus.data_pending = ms_bus.res_from_mem & ms_valid & !ms_ready_go;
    ms_forward_bus.op_tlb       = ms_valid & (ms_bus.tlb_op != TLB_NONE);
    ms_forward_bus.dest         = ms_valid ? ms_bus.dest : 5'd0;
    ms_forward_bus.final_result = ms_valid ? final_result : 32'd0;
  end

  assign ms_wr_disable = ms_valid & (ms_bus.exception.ex | (ms_bus.c0_op == C0_ERET));

  // Bus fields carried for completeness but not consumed in this stage
  logic unused_bus_bits;
  assign unused_bus_bits = &{1'b0, ms_bus.valid, ms_bus.req_ok, ms_bus.res_to_mem};

  // Discard counter must fit the worst case of two cut-off requests
  a_cancel_bound: assert property (@(posedge clk) disable iff (reset)
    cancel_next <= CANCEL_MAX);

  // A response with nothing waiting and nothing to discard breaks the protocol
  a_stray_data_ok: assert property (@(posedge clk) disable iff (reset)
    !(data_data_ok && !waiting && (cancel_cnt == '0)));

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by a
// randomized pre-MEM/SRAM environment checked against a transaction model.
`timescale 1ns/1ps
module tb_mem_stage;
  import cpu_defs::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            ws_allowin;
  logic            ms_allowin;
  pms_to_ms_bus_t  pms_to_ms_bus;
  ms_to_ws_bus_t   ms_to_ws_bus;
  ms_forward_bus_t ms_forward_bus;
  logic            ms_wr_disable;
  pipeline_flush_t pipeline_flush;
  logic [31:0]     data_rdata;
  logic            data_data_ok;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.CANCEL_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .ws_allowin     (ws_allowin),
    .ms_allowin     (ms_allowin),
    .pms_to_ms_bus  (pms_to_ms_bus),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .ms_forward_bus (ms_forward_bus),
    .ms_wr_disable  (ms_wr_disable),
    .pipeline_flush (pipeline_flush),
    .data_rdata     (data_rdata),
    .data_data_ok   (data_data_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pms_to_ms_bus  = '0;
    pipeline_flush = '0;
    data_data_ok   = 1'b0;
    data_rdata     = $urandom;
    ws_allowin     = 1'b1;
  endtask

  function automatic pms_to_ms_bus_t mk_load(input int op, input logic [31:0] vaddr,
                                             input logic [31:0] rt, input logic [4:0] dest);
    pms_to_ms_bus_t b;
    b              = '0;
    b.valid        = 1'b1;
    b.load_op      = 7'(1 << op);
    b.req_ok       = 1'b1;
    b.res_from_mem = 1'b1;
    b.rf_we        = 1'b1;
    b.dest         = dest;
    b.result       = vaddr;
    b.rt_data      = rt;
    b.pc           = $urandom;
    return b;
  endfunction

  // Reference alignment built from byte lanes (little-endian)
  function automatic logic [31:0] ref_align(input logic [6:0] op, input logic [1:0] a,
                                            input logic [31:0] rdata, input logic [31:0] rt);
    logic [7:0]  rb [4];
    logic [7:0]  tb [4];
    logic [7:0]  ob [4];
    logic [15:0] h;
    int          ai;
    ai = int'(a);
    for (int k = 0; k < 4; k++) begin
      rb[k] = rdata[8*k +: 8];
      tb[k] = rt[8*k +: 8];
    end
    h = {rb[2*(ai/2)+1], rb[2*(ai/2)]};
    if (op[LD_LW])  return rdata;
    if (op[LD_LB])  return {{24{rb[ai][7]}}, rb[ai]};
    if (op[LD_LBU]) return {24'd0, rb[ai]};
    if (op[LD_LH])  return {{16{h[15]}}, h};
    if (op[LD_LHU]) return {16'd0, h};
    if (op[LD_LWL]) begin
      for (int k = 0; k < 4; k++) ob[k] = (k >= 3 - ai) ? rb[k - (3 - ai)] : tb[k];
      return {ob[3], ob[2], ob[1], ob[0]};
    end
    if (op[LD_LWR]) begin
      for (int k = 0; k < 4; k++) ob[k] = (k <= 3 - ai) ? rb[k + ai] : tb[k];
      return {ob[3], ob[2], ob[1], ob[0]};
    end
    return 32'd0;
  endfunction

  function automatic pms_to_ms_bus_t rand_inst();
    pms_to_ms_bus_t b;
    int kind;
    kind      = $urandom_range(0, 10);
    b         = '0;
    b.valid   = 1'b1;
    b.pc      = $urandom;
    b.result  = $urandom;
    b.rt_data = $urandom;
    b.dest    = 5'($urandom);
    b.c0_addr = 8'($urandom);
    if (kind <= 6) begin
      b.load_op      = 7'(1 << kind);
      b.req_ok       = 1'b1;
      b.res_from_mem = 1'b1;
      b.rf_we        = 1'b1;
    end else if (kind == 7) begin
      b.res_to_mem = 1'b1;
      b.req_ok     = 1'b1;
    end else if (kind == 8) begin
      b.rf_we  = 1'b1;
      b.c0_op  = ($urandom_range(0, 1) != 0) ? C0_MFC0 : C0_NONE;
      b.tlb_op = tlb_op_e'($urandom_range(0, 3));
    end else if (kind == 9) begin
      b.exception.ex     = 1'b1;
      b.exception.excode = 5'($urandom);
    end else begin
      b.c0_op = C0_ERET;
    end
    return b;
  endfunction

  // Randomized-phase model state
  typedef struct {
    pms_to_ms_bus_t bus;
    logic [31:0]    rdata;
    bit             seen;
  } inst_t;

  localparam int MAX_INST = 4000;
  inst_t insts [MAX_INST];
  int    req_q [$];

  initial begin
    pms_to_ms_bus_t b;
    int  pms_id, mem_id, n_inst, retired, front;
    bit  do_flush, killed_pending, exp_valid, exp_pending, exp_allowin, exp_wrdis;
    logic [31:0] exp_res;

    // ---------------- reset state ----------------
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_allowin",  32'(ms_allowin), 32'd1);
    check("rst_ws_valid", 32'(ms_to_ws_bus.valid), 32'd0);
    check("rst_fwd_dest", 32'(ms_forward_bus.dest), 32'd0);
    check("rst_wr_dis",   32'(ms_wr_disable), 32'd0);
    check("rst_state",    32'({dut.ms_valid, dut.waiting, dut.buf_valid, dut.cancel_cnt}), 32'd0);
    reset = 1'b0;

    // ---------------- lb at ...03, zero-latency WB ----------------
    tick();
    pms_to_ms_bus = mk_load(LD_LB, 32'h1000_0003, $urandom, 5'd3);
    tick();
    pms_to_ms_bus = '0;
    data_rdata    = 32'h80AA_5511;
    #2;
    check("lb_wait_valid", 32'(ms_to_ws_bus.valid), 32'd0);
    check("lb_pending",    32'(ms_forward_bus.data_pending), 32'd1);
    check("lb_fwd_dest",   32'(ms_forward_bus.dest), 32'd3);
    data_data_ok = 1'b1;
    #1;
    check("lb_valid",   32'(ms_to_ws_bus.valid), 32'd1);
    check("lb_result",  ms_to_ws_bus.final_result, 32'hFFFF_FF80);
    check("lb_pending_clr", 32'(ms_forward_bus.data_pending), 32'd0);
    tick();
    data_data_ok = 1'b0;
    #2;
    check("lb_left", 32'(ms_to_ws_bus.valid), 32'd0);

    // ---------------- lhu at ...02 with WB stall ----------------
    pms_to_ms_bus = mk_load(LD_LHU, 32'h2000_0002, $urandom, 5'd7);
    tick();
    pms_to_ms_bus = '0;
    ws_allowin    = 1'b0;
    data_rdata    = 32'h8001_1234;
    data_data_ok  = 1'b1;
    #2;
    check("lhu_resp_valid",   32'(ms_to_ws_bus.valid), 32'd1);
    check("lhu_resp_allowin", 32'(ms_allowin), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      data_data_ok = 1'b0;
      data_rdata   = 32'h5A5A_5A5A;
      #2;
      check("lhu_buf_valid", 32'(dut.buf_valid), 32'd1);
      check("lhu_stall_allowin", 32'(ms_allowin), 32'd0);
      check("lhu_buf_result", ms_to_ws_bus.final_result, 32'h0000_8001);
    end
    tick();
    ws_allowin = 1'b1;
    #2;
    check("lhu_rel_allowin", 32'(ms_allowin), 32'd1);
    check("lhu_rel_result", ms_to_ws_bus.final_result, 32'h0000_8001);
    tick();
    #2;
    check("lhu_buf_clr", 32'(dut.buf_valid), 32'd0);
    check("lhu_left", 32'(ms_to_ws_bus.valid), 32'd0);

    // ---------------- lwl / lwr at ...01 back to back ----------------
    pms_to_ms_bus = mk_load(LD_LWL, 32'h3000_0001, 32'h1122_3344, 5'd8);
    tick();
    pms_to_ms_bus = mk_load(LD_LWR, 32'h3000_0001, 32'h1122_3344, 5'd9);
    data_rdata    = 32'hAABB_CCDD;
    data_data_ok  = 1'b1;
    #2;
    check("lwl_result", ms_to_ws_bus.final_result, 32'hCCDD_3344);
    tick();
    pms_to_ms_bus = '0;
    #2;
    check("lwr_result", ms_to_ws_bus.final_result, 32'h11AA_BBCC);
    tick();
    data_data_ok = 1'b0;

    // ---------------- flush with two cut-off requests ----------------
    pms_to_ms_bus = mk_load(LD_LW, 32'h4000_0000, 32'd0, 5'd10);
    tick();
    pms_to_ms_bus     = mk_load(LD_LW, 32'h4000_0004, 32'd0, 5'd11);
    pipeline_flush.ex = 1'b1;
    tick();
    pipeline_flush = '0;
    pms_to_ms_bus  = mk_load(LD_LW, 32'h4000_0008, 32'd0, 5'd12);
    #2;
    check("cancel_cnt2", 32'(dut.cancel_cnt), 32'd2);
    check("flush_valid", 32'(dut.ms_valid), 32'd0);
    tick();
    pms_to_ms_bus = '0;
    data_rdata    = 32'h1111_1111;
    data_data_ok  = 1'b1;
    #2;
    check("drop1_valid", 32'(ms_to_ws_bus.valid), 32'd0);
    check("drop1_pending", 32'(ms_forward_bus.data_pending), 32'd1);
    tick();
    data_rdata = 32'h2222_2222;
    #2;
    check("drop2_valid", 32'(ms_to_ws_bus.valid), 32'd0);
    check("cancel_cnt1", 32'(dut.cancel_cnt), 32'd1);
    tick();
    data_rdata = 32'hDEAD_BEEF;
    #2;
    check("cancel_cnt0", 32'(dut.cancel_cnt), 32'd0);
    check("own_valid", 32'(ms_to_ws_bus.valid), 32'd1);
    check("own_result", ms_to_ws_bus.final_result, 32'hDEAD_BEEF);
    check("own_dest", 32'(ms_to_ws_bus.dest), 32'd12);
    tick();
    data_data_ok = 1'b0;

    // ---------------- store waits, passes address ----------------
    b            = '0;
    b.valid      = 1'b1;
    b.req_ok     = 1'b1;
    b.res_to_mem = 1'b1;
    b.result     = 32'h1234_5678;
    pms_to_ms_bus = b;
    tick();
    pms_to_ms_bus = '0;
    #2;
    check("st_wait_valid", 32'(ms_to_ws_bus.valid), 32'd0);
    check("st_pending", 32'(ms_forward_bus.data_pending), 32'd0);
    tick();
    data_rdata   = $urandom;
    data_data_ok = 1'b1;
    #2;
    check("st_valid", 32'(ms_to_ws_bus.valid), 32'd1);
    check("st_result", ms_to_ws_bus.final_result, 32'h1234_5678);
    tick();
    data_data_ok = 1'b0;

    // ---------------- exception and eret: no wait, writes blocked ----------------
    b              = '0;
    b.valid        = 1'b1;
    b.exception.ex = 1'b1;
    b.result       = 32'hBFC0_0380;
    pms_to_ms_bus  = b;
    tick();
    pms_to_ms_bus = '0;
    ws_allowin    = 1'b0;
    #2;
    check("ex_valid", 32'(ms_to_ws_bus.valid), 32'd1);
    check("ex_wr_dis", 32'(ms_wr_disable), 32'd1);
    check("ex_allowin", 32'(ms_allowin), 32'd0);
    ws_allowin    = 1'b1;
    b             = '0;
    b.valid       = 1'b1;
    b.c0_op       = C0_ERET;
    pms_to_ms_bus = b;
    tick();
    pms_to_ms_bus = '0;
    #2;
    check("eret_wr_dis", 32'(ms_wr_disable), 32'd1);
    tick();
    #2;
    check("wr_dis_clr", 32'(ms_wr_disable), 32'd0);

    // ---------------- reset mid-wait ----------------
    pms_to_ms_bus = mk_load(LD_LW, 32'h5000_0000, 32'd0, 5'd4);
    tick();
    pms_to_ms_bus = '0;
    #2;
    check("mid_waiting", 32'(dut.waiting), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    check("mid_rst_state", 32'({dut.ms_valid, dut.waiting, dut.buf_valid, dut.cancel_cnt}), 32'd0);
    check("mid_rst_allowin", 32'(ms_allowin), 32'd1);
    check("mid_rst_ws_valid", 32'(ms_to_ws_bus.valid), 32'd0);

    // ---------------- randomized traffic against the transaction model ----------------
    pms_id  = -1;
    mem_id  = -1;
    n_inst  = 0;
    retired = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (pms_id < 0 && n_inst < MAX_INST && $urandom_range(0, 3) != 0) begin
        pms_id = n_inst;
        n_inst++;
        insts[pms_id].bus  = rand_inst();
        insts[pms_id].seen = 1'b0;
        if (insts[pms_id].bus.req_ok) req_q.push_back(pms_id);
      end
      pms_to_ms_bus = (pms_id >= 0) ? insts[pms_id].bus : '0;
      ws_allowin    = ($urandom_range(0, 3) != 0);

      killed_pending = 1'b0;
      foreach (req_q[i]) if (req_q[i] < 0) killed_pending = 1'b1;
      do_flush       = !killed_pending && ($urandom_range(0, 24) == 0);
      pipeline_flush = '0;
      if (do_flush) begin
        if ($urandom_range(0, 1) != 0) pipeline_flush.ex = 1'b1;
        else                           pipeline_flush.eret = 1'b1;
      end

      data_data_ok = 1'b0;
      data_rdata   = $urandom;
      if (req_q.size() > 0 && (req_q[0] < 0 || req_q[0] == mem_id) && $urandom_range(0, 1) != 0) begin
        data_data_ok = 1'b1;
        front = req_q.pop_front();
        if (front >= 0) begin
          insts[front].rdata = data_rdata;
          insts[front].seen  = 1'b1;
        end
      end
      #2;

      exp_valid   = 1'b0;
      exp_pending = 1'b0;
      exp_wrdis   = 1'b0;
      if (mem_id >= 0) begin
        exp_valid   = !insts[mem_id].bus.req_ok || insts[mem_id].seen || insts[mem_id].bus.exception.ex;
        exp_pending = insts[mem_id].bus.res_from_mem && !exp_valid;
        exp_wrdis   = insts[mem_id].bus.exception.ex || (insts[mem_id].bus.c0_op == C0_ERET);
      end
      exp_allowin = (mem_id < 0) || (exp_valid && ws_allowin);
      check("rnd_ws_valid", 32'(ms_to_ws_bus.valid), 32'(exp_valid));
      check("rnd_allowin", 32'(ms_allowin), 32'(exp_allowin));
      check("rnd_pending", 32'(ms_forward_bus.data_pending), 32'(exp_pending));
      check("rnd_wr_dis", 32'(ms_wr_disable), 32'(exp_wrdis));
      check("rnd_fwd_dest", 32'(ms_forward_bus.dest), (mem_id >= 0) ? 32'(insts[mem_id].bus.dest) : 32'd0);

      if (mem_id >= 0 && exp_valid) begin
        exp_res = insts[mem_id].bus.res_from_mem
                ? ref_align(insts[mem_id].bus.load_op, insts[mem_id].bus.result[1:0],
                            insts[mem_id].rdata, insts[mem_id].bus.rt_data)
                : insts[mem_id].bus.result;
        check("rnd_result", ms_to_ws_bus.final_result, exp_res);
        check("rnd_pc", ms_to_ws_bus.pc, insts[mem_id].bus.pc);
        if (ws_allowin && !do_flush) retired++;
      end

      if (do_flush) begin
        foreach (req_q[i]) req_q[i] = -1;
        mem_id = -1;
        pms_id = -1;
      end else if (exp_allowin) begin
        mem_id = pms_id;
        pms_id = -1;
      end
    end
    check("rnd_progress", 32'(retired > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-response stage of the five-plus-stage MIPS pipeline. It sits between pre-MEM (address/request issue) and WB.
- Accepts the pre-MEM bus and waits for the in-order data-SRAM response of a load or store.
- Aligns and extends load data, then forwards results to WB and to the ID bypass network.
- Discards responses that belong to requests killed by an exception or eret flush.

Parameters:
CANCEL_W, 2, width of the flushed-request discard counter (max 2 outstanding cancellations)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ws_allowin  in  1  WB can accept
ms_allowin  out  1  this stage can accept
pms_to_ms_bus  in  pms_to_ms_bus_t  valid, load_op, c0 fields, req_ok, res_from_mem, res_to_mem, rf_we, dest, result (=vaddr for loads), rt_data, pc, exception, tlb_op
ms_to_ws_bus  out  ms_to_ws_bus_t  valid, c0 fields, rf_we, dest, final_result, pc, exception, tlb_op
ms_forward_bus  out  ms_forward_bus_t  {op_mfc0, data_pending, op_tlb, dest, final_result}
ms_wr_disable  out  1  blocks younger CP0/memory side effects
pipeline_flush  in  pipeline_flush_t  eret/ex flush
data_rdata  in  32  SRAM read data
data_data_ok  in  1  SRAM response strobe, in request order

Behaviour:
- Reset values:
  - State: ms_valid=0, waiting=0, buf_valid=0, cancel_cnt=0.
  - Outputs: ms_allowin=1, ms_to_ws_bus.valid=0, forward dest=0, ms_wr_disable=0.
- Capture: when ms_allowin, ms_valid<=pms_to_ms_bus.valid; bus register loads only when valid&ms_allowin.
  - waiting<=pms_to_ms_bus.req_ok on capture.
- Flush (eret|ex): ms_valid<=0, waiting<=0, buf_valid<=0; flush overrides capture.
- Response steering, same cycle as data_data_ok:
  - If cancel_cnt>0: decrement cancel_cnt and drop the data.
  - Else if waiting: the response belongs to the current instruction.
- Stall buffering: if the current instruction's response arrives while ws_allowin=0, latch data_rdata into data_buf, set buf_valid, clear waiting.
  - buf_valid clears when the instruction leaves.
- cancel_cnt increment on the flush cycle = (ms_valid & waiting & no current data_ok) + (pms_to_ms_bus.req_ok). The second term covers a request issued upstream in the flush cycle.
  - Increment and decrement in the same cycle net out.
  - Counter never exceeds 2; exceeding 2 is an assertion failure.
- ms_ready_go = !waiting | own_data_ok | buf_valid | exception.ex. Here own_data_ok = data_data_ok & cancel_cnt==0 & waiting.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_bus.valid = ms_valid & ms_ready_go; combinational, 0-cycle latency from response to WB.
- Load alignment (rdata = buf_valid ? data_buf : data_rdata; a = result[1:0]):
  - lw: rdata.
  - lb/lbu: byte a, sign-/zero-extended.
  - lh/lhu: halfword a[1], sign-/zero-extended.
  - lwl: merge rdata bytes [a:0] into rt_data high end.
  - lwr: merge rdata bytes [3:a] into rt_data low end.
- final_result = res_from_mem ? aligned : result. Stores pass result unchanged.
- Forward bus:
  - All fields gated by ms_valid.
  - data_pending = res_from_mem & ms_valid & !ms_ready_go; tells ID to stall instead of bypassing.
- ms_wr_disable = ms_valid & (exception.ex | c0_op eret).
- Exception instructions never wait: pre-MEM sets req_ok=0 for them.
- data_data_ok with waiting=0 and cancel_cnt=0 is a protocol error (assertion).

Decomposition:
- cpu_defs package:
  - Bus typedefs, extended with field rt_data.
  - load_op one-hot encoding [6:0]: lw, lb, lbu, lh, lhu, lwl, lwr.
  - pipeline_flush_t.
- Sub-module load_align (combinational): inputs load_op, addr[1:0], rdata, rt_data; output 32-bit aligned value.

Test Plan:
- lb at vaddr ...03, response rdata=0x80AA5511 one cycle after capture, ws_allowin=1 -> final_result=0xFFFFFF80, WB valid the same cycle as data_ok.
- lhu at ...02, rdata=0x8001_1234, ws_allowin=0 on response for 3 cycles -> buf_valid=1, ms_allowin=0; on release final_result=0x00008001, buf_valid cleared.
- lwl at ...01, rt_data=0x11223344, rdata=0xAABBCCDD -> 0xCCDD3344; lwr at ...01 with the same inputs -> 0x11AABBCC.
- Load waiting, ex flush, plus upstream req_ok in the flush cycle -> cancel_cnt=2; the next two data_ok are dropped, the third completes the new load with its own data.
- Store (res_to_mem, req_ok=1) -> waits for data_ok, final_result=result, data_pending stays 0.
- Instruction carrying exception.ex=1 -> ready_go immediately, ms_wr_disable=1, no wait; reset asserted mid-wait -> all state 0, later stray data_ok flagged by the assertion.
